iiq_simple: RTL and testbench

//  Integer issue queue: receiving end of the dispatch->IIQ handshake. Holds up to N_ENTRIES

---
 rtl/iiq_simple_pkg.sv | 66 ++++++
 rtl/iiq_simple_select.sv | 47 ++++
 rtl/iiq_simple.sv | 152 +++++++++++++++
 tb/tb_iiq_simple.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iiq_simple_pkg.sv
// Shared types for the integer issue queue: entry layout, tag/data types and
// the per-source tag-match helpers used by the queue and its select logic.
package iiq_simple_pkg;

    localparam int ROB_ID_WIDTH   = 5;
    localparam int REG_DATA_WIDTH = 32;

    typedef logic [ROB_ID_WIDTH-1:0]   rob_id_t;
    typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;
    typedef logic [3:0]                alu_op_t;

    typedef struct packed {
        logic      valid;
        logic      ready;
        rob_id_t   rob_id;
        reg_data_t data;
    } src_t;

    typedef struct packed {
        rob_id_t instr_rob_id;
        logic    dst_valid;
        alu_op_t alu_op;
        src_t    src1;
        src_t    src2;
    } iiq_entry_t;

    function automatic logic src_avail(input src_t s);
        return ~s.valid | s.ready;
    endfunction

    // A load result both supplies data and marks the operand ready; an ALU
    // broadcast only supplies data because the issue-time wakeup already set ready.
    function automatic src_t src_capture(
        input src_t      s,
        input logic      wake_v,
        input rob_id_t   wake_id,
        input logic      alu_v,
        input rob_id_t   alu_id,
        input reg_data_t alu_d,
        input logic      ld_v,
        input rob_id_t   ld_id,
        input reg_data_t ld_d
    );
        src_t r;
        r = s;
        if (s.valid) begin
            if (wake_v && s.rob_id == wake_id) r.ready = 1'b1;
            if (alu_v && s.rob_id == alu_id) r.data = alu_d;
            if (ld_v && s.rob_id == ld_id) begin
                r.data  = ld_d;
                r.ready = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic reg_data_t src_forward(
        input src_t      s,
        input logic      alu_v,
        input rob_id_t   alu_id,
        input reg_data_t alu_d
    );
        return (alu_v && s.valid && s.rob_id == alu_id) ? alu_d : s.data;
    endfunction

endpackage

// File: rtl/iiq_simple_select.sv
// Issue select: lowest-index eligible slot by default; with IIQ_AGE_SELECT_EN
// defined, an age matrix picks the oldest eligible slot instead.
module iiq_select
    import iiq_simple_pkg::*;
#(
    parameter int N_ENTRIES = 8
) (
`ifdef IIQ_AGE_SELECT_EN
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [N_ENTRIES-1:0] valid,
    input  logic [N_ENTRIES-1:0] alloc,
    input  logic [N_ENTRIES-1:0] free,
`endif
    input  logic [N_ENTRIES-1:0] eligible,
    output logic [N_ENTRIES-1:0] grant,
    output logic                 any
);

    assign any = |eligible;

`ifdef IIQ_AGE_SELECT_EN
    // age[i][j] set means slot j is older than slot i
    logic [N_ENTRIES-1:0] age [N_ENTRIES];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int unsigned i = 0; i < N_ENTRIES; i++) age[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < N_ENTRIES; i++) begin
                if (alloc[i]) age[i] <= valid & ~free;
                else          age[i] <= age[i] & ~free;
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int unsigned i = 0; i < N_ENTRIES; i++)
            grant[i] = eligible[i] & ~|(age[i] & eligible);
    end
`else
    assign grant = eligible & (~eligible + 1'b1);
`endif

endmodule

// File: rtl/iiq_simple.sv
// Integer issue queue: accepts dispatched entries, tracks operand readiness and
// issues one eligible entry per cycle. Optional macro: IIQ_AGE_SELECT_EN.
module iiq_simple
    import iiq_simple_pkg::*;
#(
    parameter int N_ENTRIES = 8
) (
    input  logic       clk,
    input  logic       rst,
    output logic       iiq_dispatch_ready,
    input  logic       iiq_dispatch_valid,
    input  iiq_entry_t iiq_dispatch_data,
    output logic       iiq_wakeup_valid,
    output rob_id_t    iiq_wakeup_rob_id,
    input  logic       alu_issue_ready,
    output logic       alu_issue_valid,
    output iiq_entry_t alu_issue_data,
    input  logic       alu_broadcast_valid,
    input  rob_id_t    alu_broadcast_rob_id,
    input  reg_data_t  alu_broadcast_reg_data,
    input  logic       ld_broadcast_valid,
    input  rob_id_t    ld_broadcast_rob_id,
    input  reg_data_t  ld_broadcast_reg_data,
    input  logic       fetch_redirect_valid
);

    localparam int ENTRY_ID_W = $clog2(N_ENTRIES);

    logic [N_ENTRIES-1:0]  valid;
    iiq_entry_t            slots [N_ENTRIES];
    logic [N_ENTRIES-1:0]  eligible;
    logic [N_ENTRIES-1:0]  grant;
    logic [N_ENTRIES-1:0]  alloc;
    logic [N_ENTRIES-1:0]  free;
    logic                  any_eligible;
    logic                  issue_fire;
    logic                  dispatch_fire;
    logic                  alloc_found;
    logic [ENTRY_ID_W-1:0] alloc_idx;
    logic [ENTRY_ID_W-1:0] grant_idx;
    iiq_entry_t            issue_entry;
    logic                  wake_v;
    rob_id_t               wake_id;

    assign iiq_dispatch_ready = ~&valid;
    assign dispatch_fire      = iiq_dispatch_valid & iiq_dispatch_ready;

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < N_ENTRIES; i++)
            eligible[i] = valid[i] & src_avail(slots[i].src1) & src_avail(slots[i].src2);
    end

    always_comb begin
        alloc_idx   = '0;
        alloc_found = 1'b0;
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            if (!valid[i] && !alloc_found) begin
                alloc_found = 1'b1;
                alloc_idx   = ENTRY_ID_W'(i);
            end
        end
        alloc = '0;
        if (dispatch_fire) alloc[alloc_idx] = 1'b1;
    end

    iiq_select #(
        .N_ENTRIES (N_ENTRIES)
    ) u_select (
`ifdef IIQ_AGE_SELECT_EN
        .clk      (clk),
        .rst      (rst),
        .flush    (fetch_redirect_valid),
        .valid    (valid),
        .alloc    (alloc),
        .free     (free),
`endif
        .eligible (eligible),
        .grant    (grant),
        .any      (any_eligible)
    );

    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < N_ENTRIES; i++)
            if (grant[i]) grant_idx = ENTRY_ID_W'(i);
    end

    assign issue_fire  = any_eligible & alu_issue_ready;
    assign free        = issue_fire ? grant : '0;
    assign issue_entry = slots[grant_idx];
    assign wake_v      = issue_fire & issue_entry.dst_valid;
    assign wake_id     = issue_entry.instr_rob_id;

    // Consumer woken last cycle can issue now, before its ALU operand lands in the slot.
    always_comb begin
        alu_issue_data = '0;
        if (any_eligible) begin
            alu_issue_data           = issue_entry;
            alu_issue_data.src1.data = src_forward(issue_entry.src1, alu_broadcast_valid,
                                                   alu_broadcast_rob_id, alu_broadcast_reg_data);
            alu_issue_data.src2.data = src_forward(issue_entry.src2, alu_broadcast_valid,
                                                   alu_broadcast_rob_id, alu_broadcast_reg_data);
        end
    end

    assign alu_issue_valid   = any_eligible;
    assign iiq_wakeup_valid  = wake_v;
    assign iiq_wakeup_rob_id = wake_v ? wake_id : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else begin
            for (int unsigned i = 0; i < N_ENTRIES; i++) begin
                if (fetch_redirect_valid) valid[i] <= 1'b0;
                else if (free[i])         valid[i] <= 1'b0;
                else if (alloc[i])        valid[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            if (alloc[i]) begin
                slots[i] <= iiq_dispatch_data;
            end else if (valid[i]) begin
                slots[i].src1 <= src_capture(slots[i].src1, wake_v, wake_id,
                                             alu_broadcast_valid, alu_broadcast_rob_id, alu_broadcast_reg_data,
                                             ld_broadcast_valid, ld_broadcast_rob_id, ld_broadcast_reg_data);
                slots[i].src2 <= src_capture(slots[i].src2, wake_v, wake_id,
                                             alu_broadcast_valid, alu_broadcast_rob_id, alu_broadcast_reg_data,
                                             ld_broadcast_valid, ld_broadcast_rob_id, ld_broadcast_reg_data);
            end
        end
    end

    // One producer tag cannot be both an ALU and a load result in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N_ENTRIES; i++) begin
                assert (!(valid[i] && slots[i].src1.valid && alu_broadcast_valid && ld_broadcast_valid
                          && slots[i].src1.rob_id == alu_broadcast_rob_id
                          && slots[i].src1.rob_id == ld_broadcast_rob_id));
                assert (!(valid[i] && slots[i].src2.valid && alu_broadcast_valid && ld_broadcast_valid
                          && slots[i].src2.rob_id == alu_broadcast_rob_id
                          && slots[i].src2.rob_id == ld_broadcast_rob_id));
            end
        end
    end

endmodule

// File: tb/tb_iiq_simple.sv
// Bench for iiq_simple: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a slot-array model.
module tb_iiq_simple;
    import iiq_simple_pkg::*;

    logic       clk;
    logic       rst;
    logic       iiq_dispatch_ready;
    logic       iiq_dispatch_valid;
    iiq_entry_t iiq_dispatch_data;
    logic       iiq_wakeup_valid;
    rob_id_t    iiq_wakeup_rob_id;
    logic       alu_issue_ready;
    logic       alu_issue_valid;
    iiq_entry_t alu_issue_data;
    logic       alu_broadcast_valid;
    rob_id_t    alu_broadcast_rob_id;
    reg_data_t  alu_broadcast_reg_data;
    logic       ld_broadcast_valid;
    rob_id_t    ld_broadcast_rob_id;
    reg_data_t  ld_broadcast_reg_data;
    logic       fetch_redirect_valid;

    int errors = 0;
    int checks = 0;

    iiq_simple #(.N_ENTRIES(8)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .iiq_dispatch_ready     (iiq_dispatch_ready),
        .iiq_dispatch_valid     (iiq_dispatch_valid),
        .iiq_dispatch_data      (iiq_dispatch_data),
        .iiq_wakeup_valid       (iiq_wakeup_valid),
        .iiq_wakeup_rob_id      (iiq_wakeup_rob_id),
        .alu_issue_ready        (alu_issue_ready),
        .alu_issue_valid        (alu_issue_valid),
        .alu_issue_data         (alu_issue_data),
        .alu_broadcast_valid    (alu_broadcast_valid),
        .alu_broadcast_rob_id   (alu_broadcast_rob_id),
        .alu_broadcast_reg_data (alu_broadcast_reg_data),
        .ld_broadcast_valid     (ld_broadcast_valid),
        .ld_broadcast_rob_id    (ld_broadcast_rob_id),
        .ld_broadcast_reg_data  (ld_broadcast_reg_data),
        .fetch_redirect_valid   (fetch_redirect_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    iiq_entry_t  m_slot [8];
    bit          m_valid [8];
    int unsigned m_seq [8];
    int unsigned seq_ctr;
    int          sel, free_idx, n_used;
    bit          e_iv, e_fire, e_wv, e_rdy;
    iiq_entry_t  e_data;
    rob_id_t     e_wid;
    bit          last_wake_v;
    rob_id_t     last_wake_id;

    function automatic bit operand_avail(input src_t s);
        return !s.valid || s.ready;
    endfunction

    function automatic src_t absorb(input src_t s, input bit wv, input rob_id_t wid);
        src_t r = s;
        if (s.valid) begin
            if (wv && s.rob_id == wid) r.ready = 1'b1;
            if (alu_broadcast_valid && s.rob_id == alu_broadcast_rob_id) r.data = alu_broadcast_reg_data;
            if (ld_broadcast_valid && s.rob_id == ld_broadcast_rob_id) begin
                r.data  = ld_broadcast_reg_data;
                r.ready = 1'b1;
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
            seq_ctr      = 0;
            last_wake_v  = 1'b0;
            last_wake_id = '0;
        end else begin
            sel = -1;
            for (int i = 0; i < 8; i++) begin
                if (m_valid[i] && operand_avail(m_slot[i].src1) && operand_avail(m_slot[i].src2)) begin
`ifdef IIQ_AGE_SELECT_EN
                    if (sel < 0 || m_seq[i] < m_seq[sel]) sel = i;
`else
                    if (sel < 0) sel = i;
`endif
                end
            end
            e_iv   = (sel >= 0);
            e_data = '0;
            if (e_iv) begin
                e_data = m_slot[sel];
                if (alu_broadcast_valid && e_data.src1.valid && e_data.src1.rob_id == alu_broadcast_rob_id)
                    e_data.src1.data = alu_broadcast_reg_data;
                if (alu_broadcast_valid && e_data.src2.valid && e_data.src2.rob_id == alu_broadcast_rob_id)
                    e_data.src2.data = alu_broadcast_reg_data;
            end
            e_fire = e_iv && alu_issue_ready;
            e_wv   = e_fire && e_data.dst_valid;
            e_wid  = e_wv ? e_data.instr_rob_id : '0;
            n_used = 0;
            for (int i = 0; i < 8; i++) n_used += int'(m_valid[i]);
            e_rdy = (n_used < 8);

            chk("dispatch_ready", 128'(iiq_dispatch_ready), 128'(e_rdy));
            chk("issue_valid",    128'(alu_issue_valid),    128'(e_iv));
            chk("issue_data",     128'(alu_issue_data),     128'(e_data));
            chk("wakeup_valid",   128'(iiq_wakeup_valid),   128'(e_wv));
            chk("wakeup_rob_id",  128'(iiq_wakeup_rob_id),  128'(e_wid));

            free_idx = -1;
            for (int i = 0; i < 8; i++) if (!m_valid[i] && free_idx < 0) free_idx = i;
            if (fetch_redirect_valid) begin
                for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
            end else begin
                for (int i = 0; i < 8; i++) begin
                    if (m_valid[i]) begin
                        m_slot[i].src1 = absorb(m_slot[i].src1, e_wv, e_data.instr_rob_id);
                        m_slot[i].src2 = absorb(m_slot[i].src2, e_wv, e_data.instr_rob_id);
                    end
                end
                if (e_fire) m_valid[sel] = 1'b0;
                if (iiq_dispatch_valid && e_rdy) begin
                    m_valid[free_idx] = 1'b1;
                    m_slot[free_idx]  = iiq_dispatch_data;
                    m_seq[free_idx]   = seq_ctr;
                    seq_ctr++;
                end
            end
            last_wake_v  = e_wv;
            last_wake_id = e_data.instr_rob_id;
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic iiq_entry_t mk(input int rob, input bit dst,
                                      input bit s1v, input bit s1r, input int s1t,
                                      input bit s2v, input bit s2r, input int s2t);
        iiq_entry_t e = '0;
        e.instr_rob_id = rob_id_t'(rob);
        e.dst_valid    = dst;
        e.alu_op       = alu_op_t'(rob);
        e.src1.valid   = s1v;
        e.src1.ready   = s1r;
        e.src1.rob_id  = rob_id_t'(s1t);
        e.src1.data    = 32'hA100_0000 | reg_data_t'(rob);
        e.src2.valid   = s2v;
        e.src2.ready   = s2r;
        e.src2.rob_id  = rob_id_t'(s2t);
        e.src2.data    = 32'hA200_0000 | reg_data_t'(rob);
        return e;
    endfunction

    function automatic src_t rand_src();
        src_t s;
        s.valid  = ($urandom_range(0, 99) < 70);
        s.ready  = ($urandom_range(0, 99) < 50);
        s.rob_id = rob_id_t'($urandom_range(0, 31));
        s.data   = $urandom;
        return s;
    endfunction

    function automatic iiq_entry_t rand_entry();
        iiq_entry_t e;
        e.instr_rob_id = rob_id_t'($urandom_range(0, 31));
        e.dst_valid    = ($urandom_range(0, 99) < 70);
        e.alu_op       = alu_op_t'($urandom_range(0, 15));
        e.src1         = rand_src();
        e.src2         = rand_src();
        return e;
    endfunction

    task automatic idle();
        iiq_dispatch_valid     = 1'b0;
        iiq_dispatch_data      = '0;
        alu_issue_ready        = 1'b0;
        alu_broadcast_valid    = 1'b0;
        alu_broadcast_rob_id   = '0;
        alu_broadcast_reg_data = '0;
        ld_broadcast_valid     = 1'b0;
        ld_broadcast_rob_id    = '0;
        ld_broadcast_reg_data  = '0;
        fetch_redirect_valid   = 1'b0;
    endtask

    task automatic disp(input iiq_entry_t e);
        iiq_dispatch_valid = 1'b1;
        iiq_dispatch_data  = e;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1: reset state, then a ready entry issues the cycle after dispatch
        disp(mk(1, 1, 0, 0, 0, 0, 0, 0));
        alu_issue_ready = 1'b1;
        @(negedge clk);
        chk("rst_dispatch_ready", 128'(iiq_dispatch_ready), 128'(1));
        chk("rst_issue_valid",    128'(alu_issue_valid),    128'(0));
        chk("rst_wakeup_valid",   128'(iiq_wakeup_valid),   128'(0));
        chk("rst_wakeup_rob_id",  128'(iiq_wakeup_rob_id),  128'(0));
        chk("rst_issue_data",     128'(alu_issue_data),     128'(0));
        tick(); idle(); alu_issue_ready = 1'b1;
        @(negedge clk);
        chk("t1_issue_valid",   128'(alu_issue_valid),   128'(1));
        chk("t1_wakeup_valid",  128'(iiq_wakeup_valid),  128'(1));
        chk("t1_wakeup_rob_id", 128'(iiq_wakeup_rob_id), 128'(1));
        tick(); idle();

        // 2: A waits on B; B issues in N, A issues in N+1 with forwarded ALU data
        disp(mk(3, 0, 1, 0, 5, 0, 0, 0));
        tick(); idle();
        disp(mk(5, 1, 0, 0, 0, 0, 0, 0));
        tick(); idle(); alu_issue_ready = 1'b1;
        @(negedge clk);
        chk("t2_b_issue_rob",   128'(alu_issue_data.instr_rob_id), 128'(5));
        chk("t2_b_wakeup_id",   128'(iiq_wakeup_rob_id),           128'(5));
        tick(); idle(); alu_issue_ready = 1'b1;
        alu_broadcast_valid    = 1'b1;
        alu_broadcast_rob_id   = rob_id_t'(5);
        alu_broadcast_reg_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("t2_a_issue_valid", 128'(alu_issue_valid),             128'(1));
        chk("t2_a_issue_rob",   128'(alu_issue_data.instr_rob_id), 128'(3));
        chk("t2_a_src1_fwd",    128'(alu_issue_data.src1.data),    128'(32'hDEADBEEF));
        chk("t2_a_no_wakeup",   128'(iiq_wakeup_valid),            128'(0));
        tick(); idle();

        // 3: load broadcast marks operand ready and supplies its data
        disp(mk(9, 1, 0, 0, 0, 1, 0, 7));
        alu_issue_ready = 1'b1;
        tick(); idle(); alu_issue_ready = 1'b1;
        ld_broadcast_valid    = 1'b1;
        ld_broadcast_rob_id   = rob_id_t'(7);
        ld_broadcast_reg_data = 32'h1234;
        @(negedge clk);
        chk("t3_wait_issue_valid", 128'(alu_issue_valid), 128'(0));
        tick(); idle(); alu_issue_ready = 1'b1;
        @(negedge clk);
        chk("t3_issue_valid", 128'(alu_issue_valid),             128'(1));
        chk("t3_issue_rob",   128'(alu_issue_data.instr_rob_id), 128'(9));
        chk("t3_src2_data",   128'(alu_issue_data.src2.data),    128'(32'h1234));
        tick(); idle();

        // 4: fill, full blocks dispatch, one issue frees a slot next cycle
        for (int k = 0; k < 8; k++) begin
            disp(mk(10 + k, 0, 0, 0, 0, 0, 0, 0));
            tick(); idle();
        end
        disp(mk(18, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("t4_full_ready", 128'(iiq_dispatch_ready), 128'(0));
        tick(); idle(); alu_issue_ready = 1'b1;
        @(negedge clk);
        chk("t4_issue_cycle_ready", 128'(iiq_dispatch_ready),          128'(0));
        chk("t4_issue_rob",         128'(alu_issue_data.instr_rob_id), 128'(10));
        tick(); idle();
        @(negedge clk);
        chk("t4_freed_ready", 128'(iiq_dispatch_ready), 128'(1));

        // 5: refill, then flush with concurrent dispatch
        disp(mk(19, 0, 0, 0, 0, 0, 0, 0));
        tick(); idle();
        disp(mk(20, 0, 0, 0, 0, 0, 0, 0));
        fetch_redirect_valid = 1'b1;
        @(negedge clk);
        chk("t5_full_before_flush", 128'(iiq_dispatch_ready), 128'(0));
        tick(); idle();
        @(negedge clk);
        chk("t5_flush_ready",       128'(iiq_dispatch_ready), 128'(1));
        chk("t5_flush_issue_valid", 128'(alu_issue_valid),    128'(0));
        tick(); idle();

`ifdef IIQ_AGE_SELECT_EN
        // 6: slot 5 older than re-allocated slot 1
        disp(mk(21, 0, 1, 0, 31, 0, 0, 0)); tick(); idle();
        disp(mk(22, 0, 0, 0, 0, 0, 0, 0));  tick(); idle();
        for (int k = 0; k < 3; k++) begin
            disp(mk(23 + k, 0, 1, 0, 31, 0, 0, 0)); tick(); idle();
        end
        disp(mk(26, 0, 0, 0, 0, 0, 0, 0)); tick(); idle();
        alu_issue_ready = 1'b1;
        @(negedge clk);
        chk("t6_first_rob", 128'(alu_issue_data.instr_rob_id), 128'(22));
        tick(); idle();
        disp(mk(27, 0, 0, 0, 0, 0, 0, 0)); tick(); idle();
        alu_issue_ready = 1'b1;
        @(negedge clk);
        chk("t6_oldest_rob", 128'(alu_issue_data.instr_rob_id), 128'(26));
        tick(); idle();
        fetch_redirect_valid = 1'b1;
        tick(); idle();
`endif

        // randomized traffic, ALU broadcast follows the previous cycle's wakeup
        for (int c = 0; c < 3000; c++) begin
            idle();
            if ($urandom_range(0, 99) < 60) disp(rand_entry());
            alu_issue_ready        = ($urandom_range(0, 99) < 75);
            alu_broadcast_valid    = last_wake_v;
            alu_broadcast_rob_id   = last_wake_id;
            alu_broadcast_reg_data = $urandom;
            ld_broadcast_valid     = ($urandom_range(0, 99) < 30);
            ld_broadcast_rob_id    = rob_id_t'($urandom_range(0, 31));
            if (alu_broadcast_valid && ld_broadcast_rob_id == alu_broadcast_rob_id)
                ld_broadcast_rob_id = ld_broadcast_rob_id ^ rob_id_t'(1);
            ld_broadcast_reg_data  = $urandom;
            fetch_redirect_valid   = ($urandom_range(0, 99) < 2);
            tick();
        end
        idle();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
